if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

- Fetch-side endpoint of the branch redirect path: owns the PC register, issues instruction-memory requests and loads the IF/ID pipeline register.
- Consumes the `branch`/`wb_pc` redirect produced in ID and the hazard `stall`.
- Tolerates variable-latency instruction memory; a redirect that arrives while a fetch is outstanding is parked until that fetch retires.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `clk` in 1, single clock, all state on rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `stall` in 1, hazard hold: freezes PC, FSM and IF/ID.
- `branch` in 1, redirect request from ID; qualified by `id_valid`.
- `wb_pc` in 32, redirect target; valid when `branch`=1.
- `imem_req` out 1, fetch request.
- `imem_addr` out 32, fetch address (= `pc`).
- `imem_ready` in 1, fetch response valid.
- `imem_inst` in 32, fetched instruction; valid when `imem_ready`=1.
- `id_pc` out 32, IF/ID PC.
- `id_pc4` out 32, IF/ID PC+4.
- `id_inst` out 32, IF/ID instruction.
- `id_valid` out 1, IF/ID holds a real instruction.
- `redir_pend` out 1, parked redirect present (state REDIR).

## Operation
- Reset values:
  - `pc`=`RESET_PC`, `req_en`=0, state FETCH, `tgt`=0.
  - `id_pc`=`id_pc4`=`id_inst`=0, `id_valid`=0.
- `imem_req` = `req_en`. `req_en` goes to 1 at the first edge after reset release and stays 1.
- `imem_addr` = `pc` at all times.
- `take` = `imem_req & imem_ready & !stall`: the fetch retires.
- `redir` = `branch & id_valid & !stall`.
- Bubble: IF/ID loads `id_inst`=32'h0 (NOP), `id_valid`=0, `id_pc`=`id_pc4`=0.
- `stall`=1: everything holds, including a pending `imem_ready`. Memory keeps `imem_ready`/`imem_inst` stable while `imem_req` is high and `imem_addr` is unchanged.
- State FETCH, no `redir`:
  - `take`: IF/ID <= {`pc`, `pc`+4, `imem_inst`, 1}; `pc` <= `pc`+4.
  - otherwise: IF/ID <= bubble; `pc` held.
- State FETCH, `redir` and `take`:
  - `pc` <= `wb_pc`.
  - IF/ID <= bubble (wrong-path instruction squashed); see Configuration.
- State FETCH, `redir` and no `take`:
  - `tgt` <= `wb_pc`; state -> REDIR.
  - IF/ID <= bubble; `pc` held, so the outstanding address stays stable.
- State REDIR:
  - `branch` is ignored; the first target wins.
  - on `take`: `pc` <= `tgt`; state -> FETCH; IF/ID <= bubble (see Configuration).
  - otherwise: IF/ID <= bubble.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No alignment check is made on `wb_pc`.
- Reset asserted mid-fetch or in REDIR: immediate return to reset values. Any parked target is discarded.

## Timing
- Zero-wait memory (`imem_ready` high in the request cycle): one instruction per cycle. The instruction fetched in cycle N is visible on `id_*` in cycle N+1.
- First `imem_req` is in the cycle after the first rising edge following reset release.
- Redirect with `take`: `imem_addr`=`wb_pc` in the next cycle.
- Redirect without `take`: `imem_addr`=`tgt` in the cycle after the outstanding fetch retires.
- `redir_pend` is registered: high exactly while state = REDIR.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined:
  - the instruction at branch PC+4 (the fetch completing with or after the redirect) is the delay slot.
  - it loads IF/ID normally with `id_valid`=1 instead of a bubble, in both FETCH-with-take and REDIR-with-take.
- `BRANCH_DELAY_SLOT_EN` undefined: that instruction is squashed to a bubble, as specified above.

## Test plan
- Reset, `RESET_PC`=32'h0000_0100, `imem_ready`=1 constant -> `imem_addr` sequence 0x100, 0x104, 0x108. `id_pc` trails by one cycle. `id_pc4`=`id_pc`+4.
- `stall`=1 for 3 cycles with `imem_ready`=1 -> `pc`, `id_*` and state frozen. Resume fetches the same address exactly once, with no duplicate and no skip.
- Zero-wait, `branch`=1 with `id_valid`=1 and `wb_pc`=0x200 -> next `imem_addr`=0x200. IF/ID carries a bubble (undefined) or the PC+4 instruction with `id_valid`=1 (`BRANCH_DELAY_SLOT_EN`).
- `imem_ready`=0, `branch` with `wb_pc`=0x300, `imem_ready` rises 4 cycles later -> `redir_pend`=1 over that wait, `imem_addr` stable throughout, then `imem_addr`=0x300 and `redir_pend`=0.
- In REDIR, second `branch` with `wb_pc`=0x400 -> ignored; fetch resumes at 0x300. `branch` with `id_valid`=0 -> no redirect.
- `rst_n` pulsed low while in REDIR -> all outputs at reset values; fetch restarts at `RESET_PC`. PC 32'hFFFF_FFFC increments to 32'h0000_0000.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch bus between the fetch controller and the
// instruction memory. The controller is the master: it drives the request
// and address, and the memory answers with ready and the instruction word.
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_inst;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_inst
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_inst
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-side endpoint of the branch redirect path.
// Owns the PC, issues instruction-memory requests over a variable-latency
// bus and loads the IF/ID pipeline register. A redirect arriving while a
// fetch is still outstanding is parked (state REDIR) until that fetch
// retires, so the address presented to memory never changes mid-fetch.
// Optional feature macro: BRANCH_DELAY_SLOT_EN -- when defined, the fetch
// that completes with (or after) a redirect is kept as a delay-slot
// instruction instead of being squashed to a bubble.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch,
  input  logic [31:0]            wb_pc,
  if_fetch_ctrl_if.master        imem,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc4,
  output logic [31:0]            id_inst,
  output logic                   id_valid,
  output logic                   redir_pend
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  state_t      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic        req_en_q,   req_en_d;
  logic [31:0] tgt_q,      tgt_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic        id_valid_q, id_valid_d;

  logic take;
  logic redir;

  // PC arithmetic wraps modulo 2^32; no alignment is enforced.
  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

  // The outstanding fetch retires only when nothing is holding the pipe;
  // a redirect only counts when ID holds a real instruction.
  assign take  = req_en_q & imem.imem_ready & ~stall;
  assign redir = branch & id_valid_q & ~stall;

  // Next-state, PC and IF/ID load selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    // Requesting starts one edge after reset release and never stops.
    req_en_d   = 1'b1;

    if (!stall) begin
      // Default IF/ID load is a bubble; only a retiring fetch overrides it.
      id_pc_d    = 32'h0;
      id_pc4_d   = 32'h0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;

      case (state_q)
        ST_FETCH: begin
          if (redir) begin
            if (take) begin
              pc_d = wb_pc;
`ifdef BRANCH_DELAY_SLOT_EN
              id_pc_d    = pc_q;
              id_pc4_d   = pc_inc(pc_q);
              id_inst_d  = imem.imem_inst;
              id_valid_d = 1'b1;
`endif
            end else begin
              // Fetch still in flight: park the target, keep the address.
              tgt_d   = wb_pc;
              state_d = ST_REDIR;
            end
          end else if (take) begin
            id_pc_d    = pc_q;
            id_pc4_d   = pc_inc(pc_q);
            id_inst_d  = imem.imem_inst;
            id_valid_d = 1'b1;
            pc_d       = pc_inc(pc_q);
          end
        end
        ST_REDIR: begin
          // Further branches are ignored here: the first target wins.
          if (take) begin
            pc_d    = tgt_q;
            state_d = ST_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
            id_pc_d    = pc_q;
            id_pc4_d   = pc_inc(pc_q);
            id_inst_d  = imem.imem_inst;
            id_valid_d = 1'b1;
`endif
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // ---- Stage boundary: PC / FSM / IF/ID registers ----
  // All state returns to reset values immediately on rst_n, dropping any
  // parked redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_en_q   <= 1'b0;
      tgt_q      <= 32'h0;
      id_pc_q    <= 32'h0;
      id_pc4_q   <= 32'h0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_en_q   <= req_en_d;
      tgt_q      <= tgt_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem.imem_req  = req_en_q;
  assign imem.imem_addr = pc_q;
  assign id_pc          = id_pc_q;
  assign id_pc4         = id_pc4_q;
  assign id_inst        = id_inst_q;
  assign id_valid       = id_valid_q;
  assign redir_pend     = (state_q == ST_REDIR);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed test-plan steps followed by randomized
// stall/branch/memory-latency traffic, compared cycle by cycle against a
// behavioural model of the fetch rules (parked targets kept in a queue).
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] wb_pc;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        redir_pend;

  int tests;
  int fails;
  int lat;

  if_fetch_ctrl_if bus();

  if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .branch     (branch),
    .wb_pc      (wb_pc),
    .imem       (bus.master),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .redir_pend (redir_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address, so each word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_req;
  logic [31:0] park_q[$];
  logic [31:0] m_id_pc;
  logic [31:0] m_id_pc4;
  logic [31:0] m_id_inst;
  bit          m_id_v;

  task automatic model_reset();
    m_pc      = RST_PC;
    m_req     = 1'b0;
    park_q.delete();
    m_id_pc   = 32'h0;
    m_id_pc4  = 32'h0;
    m_id_inst = 32'h0;
    m_id_v    = 1'b0;
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_step(output bit fired);
    logic [31:0] npc, nid_pc, nid_pc4, nid_inst;
    bit nv, dslot;
    fired = m_req && bus.imem_ready && !stall;
    dslot = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    dslot = 1'b1;
`endif
    if (!stall) begin
      npc = m_pc;
      nid_pc = 32'h0; nid_pc4 = 32'h0; nid_inst = 32'h0; nv = 1'b0;
      if (park_q.size() != 0) begin
        if (fired) begin
          npc = park_q.pop_front();
          if (dslot) begin
            nid_pc = m_pc; nid_pc4 = m_pc + 32'd4; nid_inst = mem_word(m_pc); nv = 1'b1;
          end
        end
      end else if (branch && m_id_v) begin
        if (fired) begin
          npc = wb_pc;
          if (dslot) begin
            nid_pc = m_pc; nid_pc4 = m_pc + 32'd4; nid_inst = mem_word(m_pc); nv = 1'b1;
          end
        end else begin
          park_q.push_back(wb_pc);
        end
      end else if (fired) begin
        nid_pc = m_pc; nid_pc4 = m_pc + 32'd4; nid_inst = mem_word(m_pc); nv = 1'b1;
        npc = m_pc + 32'd4;
      end
      m_pc = npc;
      m_id_pc = nid_pc; m_id_pc4 = nid_pc4; m_id_inst = nid_inst; m_id_v = nv;
    end
    m_req = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},   {31'h0, bus.imem_req}, {31'h0, m_req});
    chk({tag, ".addr"},  bus.imem_addr, m_pc);
    chk({tag, ".id_pc"}, id_pc, m_id_pc);
    chk({tag, ".pc4"},   id_pc4, m_id_pc4);
    chk({tag, ".inst"},  id_inst, m_id_inst);
    chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, m_id_v});
    chk({tag, ".pend"},  {31'h0, redir_pend}, {31'h0, (park_q.size() != 0)});
  endtask

  task automatic step(input string tag, output bit fired);
    model_step(fired);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit f;
    tests = 0;
    fails = 0;
    lat   = 0;
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; wb_pc = 32'h0;
    bus.imem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.addr_const", bus.imem_addr, 32'h0000_0100);

    // Zero-wait streaming from RESET_PC.
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    step("first", f);
    chk("seq0.addr", bus.imem_addr, 32'h0000_0100);
    step("s1", f);
    chk("seq1.addr", bus.imem_addr, 32'h0000_0104);
    chk("seq1.id_pc", id_pc, 32'h0000_0100);
    step("s2", f);
    chk("seq2.addr", bus.imem_addr, 32'h0000_0108);
    chk("seq2.id_pc4", id_pc4, 32'h0000_0108);

    // Three stalled cycles with a ready response held.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall", f);
    chk("stall.addr", bus.imem_addr, 32'h0000_0108);
    chk("stall.id_pc", id_pc, 32'h0000_0104);
    stall = 1'b0;
    step("resume", f);
    chk("resume.id_pc", id_pc, 32'h0000_0108);
    step("resume2", f);
    chk("resume2.id_pc", id_pc, 32'h0000_010C);

    // Zero-wait redirect.
    branch = 1'b1; wb_pc = 32'h0000_0200;
    step("br_take", f);
    branch = 1'b0;
    chk("br_take.addr", bus.imem_addr, 32'h0000_0200);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("br_take.dslot_v", {31'h0, id_valid}, 32'h1);
    chk("br_take.dslot_pc", id_pc, 32'h0000_0110);
`else
    chk("br_take.bubble_v", {31'h0, id_valid}, 32'h0);
    chk("br_take.bubble_inst", id_inst, 32'h0);
`endif
    step("after_br", f);

    // Redirect parked behind a slow fetch; a second branch is ignored.
    bus.imem_ready = 1'b0;
    branch = 1'b1; wb_pc = 32'h0000_0300;
    step("park", f);
    branch = 1'b0;
    chk("park.pend", {31'h0, redir_pend}, 32'h1);
    chk("park.addr", bus.imem_addr, 32'h0000_0204);
    step("wait1", f);
    branch = 1'b1; wb_pc = 32'h0000_0400;
    step("wait2", f);
    branch = 1'b0;
    step("wait3", f);
    chk("wait.pend", {31'h0, redir_pend}, 32'h1);
    chk("wait.addr", bus.imem_addr, 32'h0000_0204);
    bus.imem_ready = 1'b1;
    step("unpark", f);
    chk("unpark.addr", bus.imem_addr, 32'h0000_0300);
    chk("unpark.pend", {31'h0, redir_pend}, 32'h0);

    // Branch while ID holds a bubble does nothing.
    bus.imem_ready = 1'b0;
    step("bubble", f);
    bus.imem_ready = 1'b1;
    branch = 1'b1; wb_pc = 32'h0000_0500;
    step("unqual", f);
    branch = 1'b0;
    chk("unqual.addr", bus.imem_addr, 32'h0000_0304);

    // Asynchronous reset while a redirect is parked.
    bus.imem_ready = 1'b0;
    branch = 1'b1; wb_pc = 32'h0000_0600;
    step("park2", f);
    branch = 1'b0;
    chk("park2.pend", {31'h0, redir_pend}, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.pend", {31'h0, redir_pend}, 32'h0);
    @(posedge clk);
    #1;
    check_all("in_rst");
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    step("restart", f);
    chk("restart.addr", bus.imem_addr, 32'h0000_0100);
    step("restart1", f);

    // PC wrap at the top of the address space.
    branch = 1'b1; wb_pc = 32'hFFFF_FFFC;
    step("to_top", f);
    branch = 1'b0;
    chk("to_top.addr", bus.imem_addr, 32'hFFFF_FFFC);
    step("wrap", f);
    chk("wrap.addr", bus.imem_addr, 32'h0000_0000);
    chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.id_pc4", id_pc4, 32'h0000_0000);

    // Randomized traffic with variable memory latency.
    lat = 0;
    for (int i = 0; i < 600; i++) begin
      stall  = ($urandom_range(0, 4) == 0);
      branch = ($urandom_range(0, 3) == 0);
      wb_pc  = $urandom;
      bus.imem_ready = (lat == 0);
      step("rnd", f);
      if (f) lat = $urandom_range(0, 3);
      else if (!stall && lat > 0) lat--;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
